ex_muldiv: RTL and testbench

Iterative integer multiply/divide unit for the RV64M instructions. It sits on the consumer side of the ID/EX pipeline register, next to the single-cycle ALU. It takes the latched operands, func3 and destination register from ID/EX and drives a stall back toward IF/ID/ID/EX while it works. On completion it delivers a 64-bit result plus a register-write request toward EX/MEM.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/ex_muldiv_if.sv | 34 +++
 rtl/cond_negate.sv | 12 +
 rtl/ex_muldiv.sv | 211 +++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV64M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side request and EX/MEM-side response bundle of ex_muldiv.
interface ex_muldiv_if;
  import muldiv_pkg::*;

  logic            start_in;
  logic            flush_in;
  logic [2:0]      func3_in;
  logic [XLEN-1:0] R1out_in;
  logic [XLEN-1:0] R2out_in;
  logic [4:0]      WReg1_in;
  logic            WRegEn_in;
  logic            stall_out;
  logic            done_out;
  logic [XLEN-1:0] result_out;
  logic [4:0]      WReg1_out;
  logic            WRegEn_out;

  modport master (
    output start_in, flush_in, func3_in,
    output R1out_in, R2out_in,
    output WReg1_in, WRegEn_in,
    input  stall_out, done_out, result_out,
    input  WReg1_out, WRegEn_out
  );

  modport slave (
    input  start_in, flush_in, func3_in,
    input  R1out_in, R2out_in,
    input  WReg1_in, WRegEn_in,
    output stall_out, done_out, result_out,
    output WReg1_out, WRegEn_out
  );

endinterface

// File: rtl/cond_negate.sv
// Two's-complement conditional negation: out = neg ? -in : in.
module cond_negate #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic [XLEN-1:0] in,
  input  logic            neg,
  output logic [XLEN-1:0] out
);

  assign out = neg ? -in : in;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit (shift-add / restoring divide).
// Define MULDIV_FAST_SPECIAL_EN to finish div-by-zero, overflow and zero-multiply ops in one cycle.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  ex_muldiv_if.slave  io
);

  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t            st;
  logic [5:0]        cnt;
  logic [2:0]        f3;
  logic              wen;
  logic              s1;
  logic              s2;
  logic              sp_hit;
  logic [XLEN-1:0]   sp_val;
  logic [XLEN-1:0]   m;
  logic [2*XLEN-1:0] acc;

  logic [2:0]        fi;
  logic              sg1;
  logic              sg2;
  logic              n1;
  logic              n2;
  logic              dz;
  logic              ovf;
  logic              fast;
  logic              start_ok;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   sp_nxt;

  assign fi       = io.func3_in;
  assign start_ok = (st == IDLE) & io.start_in
                  & ~io.flush_in;

  assign io.stall_out = ((st == IDLE) & io.start_in)
                      | (st == CALC)
                      | (st == FIX);

  always_comb begin
    sg1 = 1'b0;
    sg2 = 1'b0;
    unique case (fi)
      F3_MULH, F3_DIV, F3_REM: begin
        sg1 = 1'b1;
        sg2 = 1'b1;
      end
      F3_MULHSU: sg1 = 1'b1;
      default: ;
    endcase
  end

  assign n1 = sg1 & io.R1out_in[XLEN-1];
  assign n2 = sg2 & io.R2out_in[XLEN-1];

  cond_negate #(.XLEN(XLEN)) u_abs1 (
    .in  (io.R1out_in),
    .neg (n1),
    .out (a_mag)
  );

  cond_negate #(.XLEN(XLEN)) u_abs2 (
    .in  (io.R2out_in),
    .neg (n2),
    .out (b_mag)
  );

  assign dz  = fi[2] & (io.R2out_in == '0);
  assign ovf = ((fi == F3_DIV) | (fi == F3_REM))
             & (io.R1out_in == MIN)
             & (io.R2out_in == '1);

  // Architecturally defined results; fi[1] selects REM over DIV.
  always_comb begin
    sp_nxt = '0;
    unique case (1'b1)
      dz:  sp_nxt = fi[1] ? io.R1out_in : '1;
      ovf: sp_nxt = fi[1] ? '0 : io.R1out_in;
      default: sp_nxt = '0;
    endcase
  end

`ifdef MULDIV_FAST_SPECIAL_EN
  logic mz;
  assign mz   = ~fi[2] & ((io.R1out_in == '0)
                        | (io.R2out_in == '0));
  assign fast = dz | ovf | mz;
`else
  assign fast = 1'b0;
`endif

  // acc low half holds multiplier (mul) or dividend/quotient (div).
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN+1:0]   trial;
  logic [2*XLEN-1:0] div_nxt;

  assign sum = {1'b0, acc[2*XLEN-1:XLEN]}
             + (acc[0] ? {1'b0, m} : '0);
  assign mul_nxt = {sum, acc[XLEN-1:1]};

  assign trial = {1'b0, acc[2*XLEN-1:XLEN-1]}
               - {2'b00, m};
  assign div_nxt = trial[XLEN+1]
    ? {acc[2*XLEN-2:0], 1'b0}
    : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] fix_in;
  logic [2*XLEN-1:0] fix_out;
  logic              fix_neg;
  logic [XLEN-1:0]   fix_res;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    fix_in  = acc;
    fix_neg = s1 ^ s2;
    unique case (1'b1)
      f3[2] & f3[1]: begin
        fix_in  = {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]};
        fix_neg = s1;
      end
      f3[2] & ~f3[1]:
        fix_in = {{XLEN{1'b0}}, acc[XLEN-1:0]};
      default: ;
    endcase
  end

  cond_negate #(.XLEN(2*XLEN)) u_fix (
    .in  (fix_in),
    .neg (fix_neg),
    .out (fix_out)
  );

  assign fix_res = ((f3 == F3_MUL) | f3[2])
                 ? fix_out[XLEN-1:0]
                 : fix_out[2*XLEN-1:XLEN];
  assign fin_res = sp_hit ? sp_val : fix_res;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      st            <= IDLE;
      cnt           <= '0;
      f3            <= '0;
      wen           <= 1'b0;
      s1            <= 1'b0;
      s2            <= 1'b0;
      sp_hit        <= 1'b0;
      sp_val        <= '0;
      m             <= '0;
      acc           <= '0;
      io.result_out <= '0;
      io.WReg1_out  <= '0;
      io.WRegEn_out <= 1'b0;
      io.done_out   <= 1'b0;
    end else begin
      io.done_out   <= 1'b0;
      io.WRegEn_out <= 1'b0;
      if ((st != IDLE) && io.flush_in) begin
        st  <= IDLE;
        cnt <= '0;
      end else begin
        unique case (st)
          IDLE: begin
            if (start_ok) begin
              f3           <= fi;
              wen          <= io.WRegEn_in;
              s1           <= n1;
              s2           <= n2;
              sp_hit       <= dz | ovf;
              sp_val       <= sp_nxt;
              io.WReg1_out <= io.WReg1_in;
              cnt          <= '0;
              m   <= fi[2] ? b_mag : a_mag;
              acc <= {{XLEN{1'b0}},
                      fi[2] ? a_mag : b_mag};
              if (fast) begin
                st            <= DONE;
                io.result_out <= sp_nxt;
                io.done_out   <= 1'b1;
                io.WRegEn_out <= io.WRegEn_in;
              end else begin
                st <= CALC;
              end
            end
          end
          CALC: begin
            acc <= f3[2] ? div_nxt : mul_nxt;
            cnt <= cnt + 6'd1;
            if (cnt == 6'(XLEN-1))
              st <= FIX;
          end
          FIX: begin
            io.result_out <= fin_res;
            io.done_out   <= 1'b1;
            io.WRegEn_out <= wen;
            st            <= DONE;
          end
          DONE: st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed RV64M vectors, flush and reset.
// Expected latency follows MULDIV_FAST_SPECIAL_EN for special cases.
module tb_ex_muldiv;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .CLK (CLK),
    .RST (RST),
    .io  (bus)
  );

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wen;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.done_out) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: cyc %0d result %h expected no done",
                 cyc, bus.result_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, " result"}, bus.result_out, e.res);
        chk({e.name, " rd"}, 64'(bus.WReg1_out), 64'(e.rd));
        chk({e.name, " wen"}, 64'(bus.WRegEn_out), 64'(e.wen));
        chk({e.name, " cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, " result0"}, bus.result_out, 64'd0);
    chk({nm, " rd0"}, 64'(bus.WReg1_out), 64'd0);
    chk({nm, " wen0"}, 64'(bus.WRegEn_out), 64'd0);
    chk({nm, " done0"}, 64'(bus.done_out), 64'd0);
    chk({nm, " stall0"}, 64'(bus.stall_out), 64'd0);
  endtask

  // Called right after a negedge: drives the op in this cycle.
  task automatic start_op(input string nm, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic wen,
                          input logic [63:0] exp, input bit push,
                          input int lat);
    bus.func3_in  = f3;
    bus.R1out_in  = a;
    bus.R2out_in  = b;
    bus.WReg1_in  = rd;
    bus.WRegEn_in = wen;
    bus.start_in  = 1'b1;
    #1;
    chk({nm, " stall_at_start"}, 64'(bus.stall_out), 64'd1);
    if (push)
      sbq.push_back('{res: exp, rd: rd, wen: wen,
                      cyc: cyc + lat, name: nm});
  endtask

  task automatic wait_done(input string nm, input int lat);
    int  st_cnt;
    bit  seen;
    st_cnt = 1;
    seen   = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (k == 0) bus.start_in = 1'b0;
      if (bus.done_out) begin
        seen = 1'b1;
        chk({nm, " stall_in_done"}, 64'(bus.stall_out), 64'd0);
        break;
      end
      if (bus.stall_out) st_cnt++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done expected done", nm);
    end
    chk({nm, " stall_cycles"}, 64'(st_cnt), 64'(lat));
  endtask

  task automatic op(input string nm, input logic [2:0] f3,
                    input logic [63:0] a, input logic [63:0] b,
                    input logic [4:0] rd, input logic wen,
                    input logic [63:0] exp, input bit special);
    int lat;
    lat = (FAST && special) ? 1 : 66;
    @(negedge CLK);
    start_op(nm, f3, a, b, rd, wen, exp, 1'b1, lat);
    wait_done(nm, lat);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.start_in  = 1'b0;
    bus.flush_in  = 1'b0;
    bus.func3_in  = '0;
    bus.R1out_in  = '0;
    bus.R2out_in  = '0;
    bus.WReg1_in  = '0;
    bus.WRegEn_in = 1'b0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b1;

    op("mul", F3_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
       5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    op("mulhu", F3_MULHU, ONES, ONES,
       5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    op("mulh", F3_MULH, ONES, ONES,
       5'd7, 1'b1, 64'd0, 1'b0);
    op("mulhsu", F3_MULHSU, ONES, ONES,
       5'd8, 1'b1, ONES, 1'b0);
    op("div", F3_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
       5'd9, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    op("rem", F3_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
       5'd10, 1'b1, ONES, 1'b0);
    op("divu", F3_DIVU, 64'd100, 64'd7,
       5'd11, 1'b1, 64'd14, 1'b0);
    op("remu", F3_REMU, 64'd100, 64'd7,
       5'd12, 1'b0, 64'd2, 1'b0);
    op("divu_by0", F3_DIVU, 64'd5, 64'd0,
       5'd13, 1'b1, ONES, 1'b1);
    op("rem_by0", F3_REM, 64'd5, 64'd0,
       5'd14, 1'b1, 64'd5, 1'b1);
    op("div_neg_by0", F3_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0,
       5'd15, 1'b1, ONES, 1'b1);
    op("div_ovf", F3_DIV, MINV, ONES,
       5'd16, 1'b1, MINV, 1'b1);
    op("rem_ovf", F3_REM, MINV, ONES,
       5'd17, 1'b1, 64'd0, 1'b1);
    op("mul_zero", F3_MUL, 64'd0, 64'd123,
       5'd18, 1'b1, 64'd0, 1'b1);

    // Flush in cycle 30, restart in cycle 31.
    @(negedge CLK);
    start_op("flushed", F3_DIVU, 64'd1000, 64'd3,
             5'd19, 1'b1, 64'd0, 1'b0, 66);
    @(negedge CLK);
    bus.start_in = 1'b0;
    repeat (29) @(negedge CLK);
    bus.flush_in = 1'b1;
    @(negedge CLK);
    bus.flush_in = 1'b0;
    #1;
    chk("flush idle_stall", 64'(bus.stall_out), 64'd0);
    start_op("after_flush", F3_DIVU, 64'd1000, 64'd3,
             5'd20, 1'b1, 64'd333, 1'b1, 66);
    wait_done("after_flush", 66);

    // Reset in cycle 10 of a DIV.
    @(negedge CLK);
    start_op("reset_victim", F3_DIV, 64'd77, 64'd7,
             5'd21, 1'b1, 64'd0, 1'b0, 66);
    @(negedge CLK);
    bus.start_in = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_zero("midop_reset");
    RST = 1'b1;
    repeat (80) @(negedge CLK);
    op("after_reset", F3_MUL, 64'd12345, 64'd1000,
       5'd22, 1'b1, 64'd12345000, 1'b0);

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
